// File: rtl/fos_tdm_sched.sv
// fos_tdm_sched: time-division-multiplexed first-order IIR filter.
//
// NCH channels share a single multiply-add datapath that computes
//     y = x + b1[k]*xprev[k] + a1[k]*yprev[k]   (unsigned, modulo 2^DW)
// Each cycle a round-robin arbiter picks at most one requesting channel.
//
// Ports:
//   clk, reset            clock, synchronous active-low reset
//   in_valid/in_data      per-channel sample requests (channel k at [k*DW +: DW])
//   in_ready              one-hot grant, or all zero
//   out_valid/out_data    registered filter result, held under backpressure
//   out_ch/out_ready      channel of the result, downstream accept
//   cfg_we/cfg_clr        write coefficients / clear history of cfg_ch
//   cfg_ch/cfg_a1/cfg_b1  configuration target channel and coefficients
module fos_tdm_sched #(
    parameter int NCH = 4,
    parameter int DW  = 32,
    parameter int CW  = 11,
    localparam int CHW = $clog2(NCH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NCH-1:0]    in_valid,
    input  logic [NCH*DW-1:0] in_data,
    output logic [NCH-1:0]    in_ready,
    output logic              out_valid,
    output logic [DW-1:0]     out_data,
    output logic [CHW-1:0]    out_ch,
    input  logic              out_ready,
    input  logic              cfg_we,
    input  logic              cfg_clr,
    input  logic [CHW-1:0]    cfg_ch,
    input  logic [CW-1:0]     cfg_a1,
    input  logic [CW-1:0]     cfg_b1
);

    logic [CW-1:0]  a1_q    [NCH];
    logic [CW-1:0]  b1_q    [NCH];
    logic [DW-1:0]  xprev_q [NCH];
    logic [DW-1:0]  yprev_q [NCH];

    logic [CHW-1:0] rr_q, rr_d;
    logic           out_valid_q, out_valid_d;
    logic [DW-1:0]  out_data_q, out_data_d;
    logic [CHW-1:0] out_ch_q, out_ch_d;

    logic           slot_free;
    logic           grant_found;
    logic [CHW-1:0] grant_idx;
    logic [CHW-1:0] idx;
    logic           accept;
    logic [DW-1:0]  x;
    logic [DW-1:0]  y;

    assign slot_free = !out_valid_q || out_ready;

    // Round-robin search starting at rr_q; NCH is a power of two, so the
    // CHW-bit addition wraps from NCH-1 back to 0 on its own.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        idx         = '0;
        for (int i = 0; i < NCH; i++) begin
            idx = rr_q + CHW'(i);
            if (!grant_found && in_valid[idx]) begin
                grant_found = 1'b1;
                grant_idx   = idx;
            end
        end
    end

    // The grant is suppressed during reset so no sample is consumed while
    // the state is being cleared.
    assign accept   = reset && slot_free && grant_found;
    assign in_ready = accept ? ({{(NCH-1){1'b0}}, 1'b1} << grant_idx) : '0;

    // Shared datapath: coefficients are zero-extended and every term is
    // truncated to DW bits, which gives the required modulo-2^DW result.
    always_comb begin
        x = in_data[int'(grant_idx)*DW +: DW];
        y = x
          + DW'(b1_q[grant_idx]) * xprev_q[grant_idx]
          + DW'(a1_q[grant_idx]) * yprev_q[grant_idx];
    end

    // Next-state for the arbiter pointer and the output register. A new
    // accept always overwrites the slot; otherwise the slot drains on
    // out_ready or holds its contents.
    always_comb begin
        rr_d        = rr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        if (accept) begin
            rr_d        = grant_idx + CHW'(1);
            out_valid_d = 1'b1;
            out_data_d  = y;
            out_ch_d    = grant_idx;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // History and coefficients. The clear is written after the accept
    // update so that it wins for the stored history, while the result of
    // the same cycle was already computed from the old history.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rr_q        <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            for (int k = 0; k < NCH; k++) begin
                a1_q[k]    <= '0;
                b1_q[k]    <= '0;
                xprev_q[k] <= '0;
                yprev_q[k] <= '0;
            end
        end else begin
            rr_q        <= rr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            if (accept) begin
                xprev_q[grant_idx] <= x;
                yprev_q[grant_idx] <= y;
            end
            if (cfg_clr) begin
                xprev_q[cfg_ch] <= '0;
                yprev_q[cfg_ch] <= '0;
            end
            if (cfg_we) begin
                a1_q[cfg_ch] <= cfg_a1;
                b1_q[cfg_ch] <= cfg_b1;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_fos_tdm_sched.sv
// tb_fos_tdm_sched: directed, table-driven bench for fos_tdm_sched with the
// default parameters (NCH=4, DW=32, CW=11).
//
// Each vector drives inputs on the falling edge, checks the combinational
// grant shortly after, then checks the registered outputs just after the
// following rising edge.
module tb_fos_tdm_sched;

    localparam int NCH = 4;
    localparam int DW  = 32;
    localparam int CW  = 11;

    logic              clk;
    logic              reset;
    logic [NCH-1:0]    in_valid;
    logic [NCH*DW-1:0] in_data;
    logic [NCH-1:0]    in_ready;
    logic              out_valid;
    logic [DW-1:0]     out_data;
    logic [1:0]        out_ch;
    logic              out_ready;
    logic              cfg_we;
    logic              cfg_clr;
    logic [1:0]        cfg_ch;
    logic [CW-1:0]     cfg_a1;
    logic [CW-1:0]     cfg_b1;

    int checkCount = 0;
    int failCount  = 0;

    typedef struct {
        logic              rst;
        logic              we;
        logic              clr;
        logic [1:0]        cch;
        logic [CW-1:0]     a1;
        logic [CW-1:0]     b1;
        logic [NCH-1:0]    iv;
        logic [NCH*DW-1:0] data;
        logic              ordy;
        logic [NCH-1:0]    expRdy;
        logic              expOv;
        logic [DW-1:0]     expOd;
        logic [1:0]        expCh;
        logic              chkData;
    } vec_t;

    vec_t vecs[$];

    fos_tdm_sched #(.NCH(NCH), .DW(DW), .CW(CW)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_ready (out_ready),
        .cfg_we    (cfg_we),
        .cfg_clr   (cfg_clr),
        .cfg_ch    (cfg_ch),
        .cfg_a1    (cfg_a1),
        .cfg_b1    (cfg_b1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [NCH*DW-1:0] pk(input logic [DW-1:0] d3, input logic [DW-1:0] d2,
                                             input logic [DW-1:0] d1, input logic [DW-1:0] d0);
        return {d3, d2, d1, d0};
    endfunction

    function automatic vec_t mk(input logic rst, input logic we, input logic clr,
                                input logic [1:0] cch, input logic [CW-1:0] a1,
                                input logic [CW-1:0] b1, input logic [NCH-1:0] iv,
                                input logic [NCH*DW-1:0] data, input logic ordy,
                                input logic [NCH-1:0] expRdy, input logic expOv,
                                input logic [DW-1:0] expOd, input logic [1:0] expCh,
                                input logic chkData);
        vec_t v;
        v.rst = rst; v.we = we; v.clr = clr; v.cch = cch; v.a1 = a1; v.b1 = b1;
        v.iv = iv; v.data = data; v.ordy = ordy; v.expRdy = expRdy;
        v.expOv = expOv; v.expOd = expOd; v.expCh = expCh; v.chkData = chkData;
        return v;
    endfunction

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checkCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one vector on the falling edge and check the grant it produces.
    task automatic applyStimulus(input vec_t v, input int n);
        @(negedge clk);
        reset     = v.rst;
        cfg_we    = v.we;
        cfg_clr   = v.clr;
        cfg_ch    = v.cch;
        cfg_a1    = v.a1;
        cfg_b1    = v.b1;
        in_valid  = v.iv;
        in_data   = v.data;
        out_ready = v.ordy;
        #1;
        check($sformatf("in_ready[v%0d]", n), DW'(in_ready), DW'(v.expRdy));
    endtask

    // Check the registered outputs just after the next rising edge.
    task automatic checkOutput(input vec_t v, input int n);
        @(posedge clk);
        #1;
        check($sformatf("out_valid[v%0d]", n), DW'(out_valid), DW'(v.expOv));
        if (v.chkData) begin
            check($sformatf("out_data[v%0d]", n), out_data, v.expOd);
            check($sformatf("out_ch[v%0d]", n), DW'(out_ch), DW'(v.expCh));
        end
    endtask

    task automatic runVector(input vec_t v, input int n);
        applyStimulus(v, n);
        checkOutput(v, n);
    endtask

    initial begin
        reset     = 1'b0;
        in_valid  = '0;
        in_data   = '0;
        out_ready = 1'b0;
        cfg_we    = 1'b0;
        cfg_clr   = 1'b0;
        cfg_ch    = '0;
        cfg_a1    = '0;
        cfg_b1    = '0;

        // Reset with requests present: no grant, cleared outputs.
        vecs.push_back(mk(0,0,0,0,0,0,4'hF,pk(13,12,11,10),1, 4'h0,0,0,0,1));
        vecs.push_back(mk(0,0,0,0,0,0,4'hF,pk(13,12,11,10),1, 4'h0,0,0,0,1));
        // All channels requesting: grants 0,1,2,3,0; zero coefficients give y = x.
        vecs.push_back(mk(1,0,0,0,0,0,4'hF,pk(13,12,11,10),1, 4'b0001,1,10,0,1));
        vecs.push_back(mk(1,0,0,0,0,0,4'hF,pk(13,12,11,10),1, 4'b0010,1,11,1,1));
        vecs.push_back(mk(1,0,0,0,0,0,4'hF,pk(13,12,11,10),1, 4'b0100,1,12,2,1));
        vecs.push_back(mk(1,0,0,0,0,0,4'hF,pk(13,12,11,10),1, 4'b1000,1,13,3,1));
        vecs.push_back(mk(1,0,0,0,0,0,4'hF,pk(13,12,11,10),1, 4'b0001,1,10,0,1));
        // ch0: write a1=2, b1=3 and clear history together, then x=1, x=1 -> 1, 6.
        vecs.push_back(mk(1,1,1,0,2,3,4'h0,pk(0,0,0,0),1, 4'h0,0,0,0,0));
        vecs.push_back(mk(1,0,0,0,0,0,4'b0001,pk(0,0,0,1),1, 4'b0001,1,1,0,1));
        vecs.push_back(mk(1,0,0,0,0,0,4'b0001,pk(0,0,0,1),1, 4'b0001,1,6,0,1));
        // Backpressure for 3 cycles: no grant, output held; then ch1 accepted.
        vecs.push_back(mk(1,0,0,0,0,0,4'b0010,pk(0,0,100,0),0, 4'h0,1,6,0,1));
        vecs.push_back(mk(1,0,0,0,0,0,4'b0010,pk(0,0,100,0),0, 4'h0,1,6,0,1));
        vecs.push_back(mk(1,0,0,0,0,0,4'b0010,pk(0,0,100,0),0, 4'h0,1,6,0,1));
        vecs.push_back(mk(1,0,0,0,0,0,4'b0010,pk(0,0,100,0),1, 4'b0010,1,100,1,1));
        vecs.push_back(mk(1,0,0,0,0,0,4'h0,pk(0,0,0,0),1, 4'h0,0,0,0,0));
        // ch1 overflow: preload history to all-ones, coefficient write concurrent
        // with an accept still uses the old (zero) coefficients, then wraps.
        vecs.push_back(mk(1,0,0,0,0,0,4'b0010,pk(0,0,32'hFFFF_FFFF,0),1, 4'b0010,1,32'hFFFF_FFFF,1,1));
        vecs.push_back(mk(1,1,0,1,2047,2047,4'b0010,pk(0,0,32'hFFFF_FFFF,0),1, 4'b0010,1,32'hFFFF_FFFF,1,1));
        vecs.push_back(mk(1,0,0,0,0,0,4'b0010,pk(0,0,32'hFFFF_FFFF,0),1, 4'b0010,1,32'hFFFF_F001,1,1));
        // ch2: build history x=7/y=9 using b1=1, then a1=b1=1 and clear with accept.
        vecs.push_back(mk(1,1,1,2,0,1,4'h0,pk(0,0,0,0),1, 4'h0,0,0,0,0));
        vecs.push_back(mk(1,0,0,0,0,0,4'b0100,pk(0,2,0,0),1, 4'b0100,1,2,2,1));
        vecs.push_back(mk(1,0,0,0,0,0,4'b0100,pk(0,7,0,0),1, 4'b0100,1,9,2,1));
        vecs.push_back(mk(1,1,0,2,1,1,4'h0,pk(0,0,0,0),1, 4'h0,0,0,0,0));
        vecs.push_back(mk(1,0,1,2,0,0,4'b0100,pk(0,5,0,0),1, 4'b0100,1,21,2,1));
        vecs.push_back(mk(1,0,0,0,0,0,4'b0100,pk(0,5,0,0),1, 4'b0100,1,5,2,1));
        // ch0 state untouched by ch1/ch2 activity; pointer wraps 3 -> 0.
        vecs.push_back(mk(1,0,0,0,0,0,4'b0001,pk(0,0,0,1),1, 4'b0001,1,16,0,1));

        foreach (vecs[i]) runVector(vecs[i], i);

        // Reset in the middle of a stalled transfer: the pending result is
        // dropped, and afterwards every channel behaves as y = x from rr = 0.
        runVector(mk(1,0,0,0,0,0,4'b0001,pk(0,0,0,1),0, 4'h0,1,16,0,1), 100);
        runVector(mk(0,0,0,0,0,0,4'hF,pk(9,3,7,5),0, 4'h0,0,0,0,1), 101);
        runVector(mk(1,0,0,0,0,0,4'hF,pk(9,3,7,5),1, 4'b0001,1,5,0,1), 102);
        runVector(mk(1,0,0,0,0,0,4'hF,pk(9,3,7,5),1, 4'b0010,1,7,1,1), 103);
        runVector(mk(1,0,0,0,0,0,4'hF,pk(9,3,7,5),1, 4'b0100,1,3,2,1), 104);

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
